// File: rtl/peri_irq_ctrl.sv
// Peripheral interrupt controller.
// Level-sensitive sources latch into sticky pending flops. A claim hands the
// lowest-indexed enabled pending source to software and moves it to
// in-service. A completion releases it so that a still-high source can
// re-pend.
// Source IDs are 1-based. ID 0 means "no source".

module peri_irq_ctrl #(
  parameter int NumSrc = 46,
  parameter int IdW    = $clog2(NumSrc + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] intr_src_i,
  input  logic [NumSrc-1:0] intr_en_i,
  input  logic              claim_i,
  output logic              claim_valid_o,
  output logic [IdW-1:0]    claim_id_o,
  input  logic              complete_i,
  input  logic [IdW-1:0]    complete_id_i,
  output logic              irq_o,
  output logic [NumSrc-1:0] pending_o
);

  logic [NumSrc-1:0] pending_q;
  logic [NumSrc-1:0] pending_d;
  logic [NumSrc-1:0] in_service_q;
  logic [NumSrc-1:0] in_service_d;
  logic [NumSrc-1:0] eligible;
  logic [NumSrc-1:0] set_mask;
  logic [NumSrc-1:0] claim_mask;
  logic [NumSrc-1:0] complete_mask;
  logic [NumSrc-1:0] win_onehot;
  logic              win_valid;
  logic [IdW-1:0]    win_id;

  // Only enabled sources compete. The enable never blocks latching.
  assign eligible = pending_q & intr_en_i;

  // A source may only latch when it is neither pending nor being serviced.
  // A source that stays high therefore re-pends one edge after completion.
  assign set_mask = intr_src_i & ~pending_q & ~in_service_q;

  // Fixed-priority arbiter: the lowest index wins.
  always_comb begin
    win_valid  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (eligible[i] && !win_valid) begin
        win_valid     = 1'b1;
        win_id        = IdW'(i + 1);
        win_onehot[i] = 1'b1;
      end
    end
  end

  // The claimed source must be the current winner. An empty claim touches nothing.
  assign claim_mask = claim_i ? win_onehot : '0;

  // Decode the completion ID. ID 0, out-of-range IDs and sources that are
  // not in service produce no bit.
  always_comb begin
    complete_mask = '0;
    for (int i = 0; i < NumSrc; i++) begin
      complete_mask[i] = complete_i && (complete_id_i == IdW'(i + 1)) && in_service_q[i];
    end
  end

  // A winner is always pending already, so it never collides with its own
  // set bit. Pending and in-service stay mutually exclusive per source.
  // This lets a claim and a completion in the same cycle apply independently.
  assign pending_d    = (pending_q | set_mask) & ~claim_mask;
  assign in_service_d = (in_service_q | claim_mask) & ~complete_mask;

  // Pending and in-service state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  // irq_o is registered from the current eligible set, so it trails pending by one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |eligible;
    end
  end

  // Claim response: the valid flag pulses once per claim. The ID holds until the next claim.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
    end else begin
      claim_valid_o <= claim_i;
      if (claim_i) begin
        claim_id_o <= win_valid ? win_id : '0;
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_peri_irq_ctrl.sv
module tb_peri_irq_ctrl;
  localparam int N = 46;
  localparam int W = 6;

  logic         clk, rst_n;
  logic [N-1:0] src, en;
  logic         claim, complete;
  logic [W-1:0] cid_in;
  logic         claim_valid, irq;
  logic [W-1:0] claim_id;
  logic [N-1:0] pending;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [N-1:0] m_pend, m_insv;
  logic         m_irq, m_cv;
  logic [W-1:0] m_cid;

  peri_irq_ctrl #(.NumSrc(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .intr_src_i(src), .intr_en_i(en),
    .claim_i(claim), .claim_valid_o(claim_valid), .claim_id_o(claim_id),
    .complete_i(complete), .complete_id_i(cid_in), .irq_o(irq), .pending_o(pending)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    m_pend = '0; m_insv = '0; m_irq = 0; m_cv = 0; m_cid = '0;
  endtask

  // Advance one clock edge and step the model using the inputs held before the edge.
  task automatic tick();
    logic [N-1:0] np, ni;
    logic         ncv, nirq;
    logic [W-1:0] ncid;
    int           w, k;
    np = m_pend; ni = m_insv; ncid = m_cid; ncv = 0; nirq = 0; w = -1;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && en[i]) begin
        nirq = 1;
        if (w < 0) w = i;
      end
      if (src[i] && !m_pend[i] && !m_insv[i]) np[i] = 1;
    end
    if (claim) begin
      ncv = 1;
      if (w >= 0) begin
        np[w] = 0; ni[w] = 1; ncid = W'(w + 1);
      end else begin
        ncid = '0;
      end
    end
    k = int'(cid_in);
    if (complete && k >= 1 && k <= N) begin
      if (m_insv[k-1]) ni[k-1] = 0;
    end
    if (!rst_n) begin
      np = '0; ni = '0; ncv = 0; ncid = '0; nirq = 0;
    end
    @(posedge clk);
    #1;
    m_pend = np; m_insv = ni; m_cv = ncv; m_cid = ncid; m_irq = nirq;
  endtask

  task automatic test_reset();
    rst_n = 0; src = '0; src[0] = 1'b1; en = '1; claim = 0; complete = 0; cid_in = '0;
    model_clear();
    #8;
    n_vec++; if (pending !== '0) begin n_err++; $display("FAIL rst_pending got=%h exp=0", pending); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b exp=0", irq); end
    n_vec++; if (claim_valid !== 1'b0) begin n_err++; $display("FAIL rst_cv got=%b exp=0", claim_valid); end
    n_vec++; if (claim_id !== '0) begin n_err++; $display("FAIL rst_cid got=%0d exp=0", claim_id); end
    #4 rst_n = 1;
    #1;
    n_vec++; if (pending !== '0) begin n_err++; $display("FAIL rst_release_pending got=%h exp=0", pending); end
    src = '0;
    tick();
  endtask

  task automatic test_single_claim();
    src = '0; src[3] = 1'b1;
    tick();
    n_vec++; if (pending !== 46'h8) begin n_err++; $display("FAIL single_pend got=%h exp=8", pending); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq0 got=%b exp=0", irq); end
    src = '0;
    tick();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq1 got=%b exp=1", irq); end
    n_vec++; if (pending !== 46'h8) begin n_err++; $display("FAIL single_sticky got=%h exp=8", pending); end
    claim = 1;
    tick();
    claim = 0;
    n_vec++; if (claim_valid !== 1'b1) begin n_err++; $display("FAIL single_cv got=%b exp=1", claim_valid); end
    n_vec++; if (claim_id !== 6'd4) begin n_err++; $display("FAIL single_cid got=%0d exp=4", claim_id); end
    n_vec++; if (pending !== '0) begin n_err++; $display("FAIL single_clr got=%h exp=0", pending); end
    tick();
    n_vec++; if (claim_valid !== 1'b0) begin n_err++; $display("FAIL single_cv_pulse got=%b exp=0", claim_valid); end
    n_vec++; if (claim_id !== 6'd4) begin n_err++; $display("FAIL single_cid_hold got=%0d exp=4", claim_id); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq_drop got=%b exp=0", irq); end
    complete = 1; cid_in = 6'd4;
    tick();
    complete = 0;
  endtask

  task automatic test_back_to_back();
    src = '0; src[5] = 1'b1; src[9] = 1'b1;
    tick();
    n_vec++; if (pending !== 46'h220) begin n_err++; $display("FAIL b2b_pend got=%h exp=220", pending); end
    src = '0;
    tick();
    claim = 1;
    tick();
    n_vec++; if (claim_valid !== 1'b1 || claim_id !== 6'd6) begin n_err++; $display("FAIL b2b_first got=%b/%0d exp=1/6", claim_valid, claim_id); end
    n_vec++; if (pending !== 46'h200) begin n_err++; $display("FAIL b2b_pend1 got=%h exp=200", pending); end
    tick();
    n_vec++; if (claim_valid !== 1'b1 || claim_id !== 6'd10) begin n_err++; $display("FAIL b2b_second got=%b/%0d exp=1/10", claim_valid, claim_id); end
    tick();
    n_vec++; if (claim_valid !== 1'b1 || claim_id !== 6'd0) begin n_err++; $display("FAIL b2b_third got=%b/%0d exp=1/0", claim_valid, claim_id); end
    claim = 0;
    tick();
    n_vec++; if (claim_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b/%b exp=0/0", claim_valid, irq); end
    complete = 1; cid_in = 6'd6;
    tick();
    cid_in = 6'd10;
    tick();
    complete = 0;
  endtask

  task automatic test_retrigger();
    src = '0; src[7] = 1'b1;
    tick();
    tick();
    claim = 1;
    tick();
    claim = 0;
    n_vec++; if (claim_id !== 6'd8) begin n_err++; $display("FAIL retrig_cid got=%0d exp=8", claim_id); end
    tick();
    n_vec++; if (pending !== '0) begin n_err++; $display("FAIL retrig_blocked got=%h exp=0", pending); end
    complete = 1; cid_in = 6'd8;
    tick();
    complete = 0;
    n_vec++; if (pending !== '0) begin n_err++; $display("FAIL retrig_edgeN got=%h exp=0", pending); end
    tick();
    n_vec++; if (pending !== 46'h80 || irq !== 1'b0) begin n_err++; $display("FAIL retrig_N1 got=%h/%b exp=80/0", pending, irq); end
    tick();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL retrig_N2_irq got=%b exp=1", irq); end
    src = '0; claim = 1;
    tick();
    claim = 0; complete = 1; cid_in = 6'd8;
    tick();
    complete = 0;
  endtask

  task automatic test_enable_gate();
    en = '1; en[0] = 1'b0; src = '0; src[0] = 1'b1;
    tick();
    n_vec++; if (pending !== 46'h1) begin n_err++; $display("FAIL en_pend got=%h exp=1", pending); end
    src = '0;
    tick();
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL en_irq_masked got=%b exp=0", irq); end
    claim = 1;
    tick();
    claim = 0;
    n_vec++; if (claim_valid !== 1'b1 || claim_id !== 6'd0) begin n_err++; $display("FAIL en_claim_none got=%b/%0d exp=1/0", claim_valid, claim_id); end
    n_vec++; if (pending !== 46'h1) begin n_err++; $display("FAIL en_keep got=%h exp=1", pending); end
    en = '1;
    tick();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL en_irq_on got=%b exp=1", irq); end
    claim = 1;
    tick();
    claim = 0;
    n_vec++; if (claim_id !== 6'd1 || pending !== '0) begin n_err++; $display("FAIL en_claim got=%0d/%h exp=1/0", claim_id, pending); end
    complete = 1; cid_in = 6'd1;
    tick();
    complete = 0;
  endtask

  task automatic test_bad_complete();
    src = '0; src[2] = 1'b1;
    tick();
    src = '0; complete = 1;
    cid_in = 6'd0;  tick();
    cid_in = 6'd47; tick();
    cid_in = 6'd20; tick();
    cid_in = 6'd3;  tick();
    complete = 0;
    n_vec++; if (pending !== 46'h4 || irq !== 1'b1) begin n_err++; $display("FAIL badc_pend got=%h/%b exp=4/1", pending, irq); end
    claim = 1;
    tick();
    claim = 0;
    n_vec++; if (claim_id !== 6'd3) begin n_err++; $display("FAIL badc_cid got=%0d exp=3", claim_id); end
    complete = 1;
    cid_in = 6'd0;  tick();
    cid_in = 6'd47; tick();
    complete = 0; src[2] = 1'b1;
    tick();
    tick();
    n_vec++; if (pending !== '0) begin n_err++; $display("FAIL badc_still_insv got=%h exp=0", pending); end
    complete = 1; cid_in = 6'd3;
    tick();
    complete = 0;
    tick();
    n_vec++; if (pending !== 46'h4) begin n_err++; $display("FAIL badc_repend got=%h exp=4", pending); end
    src = '0; claim = 1;
    tick();
    claim = 0; complete = 1; cid_in = 6'd3;
    tick();
    complete = 0;
  endtask

  task automatic test_reset_mid_claim();
    src = '0; src[1] = 1'b1;
    tick();
    tick();
    claim = 1;
    #2 rst_n = 0;
    #1;
    model_clear();
    n_vec++; if (pending !== '0 || irq !== 1'b0) begin n_err++; $display("FAIL rstmid_state got=%h/%b exp=0/0", pending, irq); end
    n_vec++; if (claim_valid !== 1'b0 || claim_id !== '0) begin n_err++; $display("FAIL rstmid_claim got=%b/%0d exp=0/0", claim_valid, claim_id); end
    tick();
    n_vec++; if (claim_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_nopulse got=%b exp=0", claim_valid); end
    claim = 0; src = '0; rst_n = 1;
  endtask

  task automatic test_random();
    logic [63:0] r1, r2, r3;
    int k;
    for (int c = 0; c < 400; c++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      r3 = {$urandom(), $urandom()};
      src = r1[N-1:0] & r2[N-1:0] & r3[N-1:0];
      r1 = {$urandom(), $urandom()};
      en = ~(r1[N-1:0] & r2[N-1:0]);
      claim = ($urandom_range(0, 2) == 0);
      complete = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cid_in = W'($urandom_range(0, 63));
      end else begin
        cid_in = '0;
        k = $urandom_range(0, N - 1);
        for (int j = 0; j < N; j++) begin
          if (cid_in == '0 && m_insv[(k + j) % N]) cid_in = W'(((k + j) % N) + 1);
        end
      end
      tick();
      n_vec++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, pending, m_pend); end
      n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", c, irq, m_irq); end
      n_vec++; if (claim_valid !== m_cv) begin n_err++; $display("FAIL rnd_cv cyc=%0d got=%b exp=%b", c, claim_valid, m_cv); end
      n_vec++; if (claim_id !== m_cid) begin n_err++; $display("FAIL rnd_cid cyc=%0d got=%0d exp=%0d", c, claim_id, m_cid); end
    end
    src = '0; claim = 0; complete = 0; en = '1;
  endtask

  initial begin
    test_reset();
    test_single_claim();
    test_back_to_back();
    test_retrigger();
    test_enable_gate();
    test_bad_complete();
    test_reset_mid_claim();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
